// File: rtl/ram82s21_wr.sv
// ram82s21_wr: write sequencer for a Signetics 82S21 32x2 bipolar RAM slice.
// Buffers one write request and drives A/I/CE plus the WE0_N/WE1_N/WCLK_N
// strobes through programmable setup, pulse and hold windows. While idle the
// RAM address follows rd_addr so downstream readers see live data.
// Optional feature: define RAM82S21_VERIFY_EN to add a readback-and-compare
// phase (VREAD/VCMP) that flags mismatches on verify_err.
module ram82s21_wr #(
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned PULSE_CYC = 2,
  parameter int unsigned HOLD_CYC  = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [4:0] req_addr,
  input  logic [1:0] req_data,
  input  logic [1:0] req_mask,
  input  logic [4:0] rd_addr,
  output logic [4:0] A,
  output logic [1:0] I,
  output logic       CE,
  output logic       WE0_N,
  output logic       WE1_N,
  output logic       WCLK_N,
  output logic       LATCH_N,
  input  logic [1:0] ram_d,
  output logic       busy,
  output logic       done,
  output logic       verify_err
);

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 2;
  localparam int unsigned CNT_W  = 4;

  // Counter reload values for each window (counter counts down to zero).
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'((HOLD_CYC == 0) ? 0 : HOLD_CYC - 1);

  // Reject window lengths the 4-bit counter cannot represent.
  if (SETUP_CYC < 1 || SETUP_CYC > 15) begin : g_bad_setup
    $error("ram82s21_wr: SETUP_CYC must be 1..15");
  end
  if (PULSE_CYC < 1 || PULSE_CYC > 15) begin : g_bad_pulse
    $error("ram82s21_wr: PULSE_CYC must be 1..15");
  end
  if (HOLD_CYC > 15) begin : g_bad_hold
    $error("ram82s21_wr: HOLD_CYC must be 0..15");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD
`ifdef RAM82S21_VERIFY_EN
    ,
    ST_VREAD,
    ST_VCMP
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] mask_q, mask_d;
  logic              ce_q, ce_d;
  logic              we0_n_q, we0_n_d;
  logic              we1_n_q, we1_n_d;
  logic              wclk_n_q, wclk_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              req_ready_q, req_ready_d;
  logic              wr_end;

`ifdef RAM82S21_VERIFY_EN
  logic              verify_err_q, verify_err_d;
  logic              mismatch_c;

  // Readback compare: only bits that were actually written are checked.
  always_comb begin
    mismatch_c = |((ram_d ^ data_q) & mask_q);
  end
`else
  logic [DATA_W-1:0] unused_ram_d;
  assign unused_ram_d = ram_d;
`endif

  // Next-state, counter and next registered pin values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    mask_d  = mask_q;
    done_d  = 1'b0;
    wr_end  = 1'b0;
`ifdef RAM82S21_VERIFY_EN
    verify_err_d = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          addr_d  = req_addr;
          data_d  = req_data;
          mask_d  = req_mask;
          cnt_d   = SETUP_LD;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          cnt_d   = PULSE_LD;
          state_d = ST_PULSE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_PULSE: begin
        if (cnt_q == '0) begin
          if (HOLD_CYC == 0) begin
            wr_end = 1'b1;
          end else begin
            cnt_d   = HOLD_LD;
            state_d = ST_HOLD;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          wr_end = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`ifdef RAM82S21_VERIFY_EN
      ST_VREAD: begin
        state_d = ST_VCMP;
      end
      ST_VCMP: begin
        state_d      = ST_IDLE;
        done_d       = 1'b1;
        verify_err_d = mismatch_c;
      end
`endif
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // End of the write strobe sequence: read back or finish.
    if (wr_end) begin
      cnt_d = '0;
`ifdef RAM82S21_VERIFY_EN
      state_d = ST_VREAD;
`else
      state_d = ST_IDLE;
      done_d  = 1'b1;
`endif
    end

    // RAM control pins are decoded from the next state so they are flops.
    ce_d        = !((state_d == ST_SETUP) || (state_d == ST_PULSE) || (state_d == ST_HOLD));
    we0_n_d     = !((state_d == ST_PULSE) && mask_d[0]);
    we1_n_d     = !((state_d == ST_PULSE) && mask_d[1]);
    wclk_n_d    = !(state_d == ST_PULSE);
    busy_d      = (state_d != ST_IDLE);
    req_ready_d = (state_d == ST_IDLE);
  end

  // State, request copy and registered outputs; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      mask_q      <= '0;
      ce_q        <= 1'b1;
      we0_n_q     <= 1'b1;
      we1_n_q     <= 1'b1;
      wclk_n_q    <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      req_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      mask_q      <= mask_d;
      ce_q        <= ce_d;
      we0_n_q     <= we0_n_d;
      we1_n_q     <= we1_n_d;
      wclk_n_q    <= wclk_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      req_ready_q <= req_ready_d;
    end
  end

`ifdef RAM82S21_VERIFY_EN
  // Verify error flag, pulsed together with done.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      verify_err_q <= 1'b0;
    end else begin
      verify_err_q <= verify_err_d;
    end
  end
  assign verify_err = verify_err_q;
`else
  assign verify_err = 1'b0;
`endif

  // Idle address tracks the live read address; otherwise the held write address.
  assign A         = (state_q == ST_IDLE) ? rd_addr : addr_q;
  assign I         = data_q;
  assign CE        = ce_q;
  assign WE0_N     = we0_n_q;
  assign WE1_N     = we1_n_q;
  assign WCLK_N    = wclk_n_q;
  assign LATCH_N   = 1'b1;
  assign busy      = busy_q;
  assign done      = done_q;
  assign req_ready = req_ready_q;

endmodule

// File: tb/tb_ram82s21_wr.sv
// Bench for ram82s21_wr: default-parameter instance driving a 32x2 RAM model
// with a write scoreboard, plus a PULSE_CYC=1/HOLD_CYC=0 instance.
module tb_ram82s21_wr;

`ifdef RAM82S21_VERIFY_EN
  localparam int VLAT = 2;
`else
  localparam int VLAT = 0;
`endif
  localparam int LAT  = 4 + VLAT;   // 1 setup + 2 pulse + 1 hold
  localparam int LAT2 = 2 + VLAT;   // 1 setup + 1 pulse + 0 hold

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req_valid, req_valid2;
  logic       req_ready, req_ready2;
  logic [4:0] req_addr, rd_addr;
  logic [1:0] req_data, req_mask;
  logic [4:0] A, A2;
  logic [1:0] I, I2, ram_d;
  logic       CE, WE0_N, WE1_N, WCLK_N, LATCH_N, busy, done, verify_err;
  logic       CE2, WE0_N2, WE1_N2, WCLK_N2, LATCH_N2, busy2, done2, verify_err2;
  logic       stuck_d0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  int push_cnt = 0;

  typedef struct {
    logic [4:0] addr;
    logic [1:0] word;
    logic       verr;
    int         acc;
  } exp_t;
  exp_t sb[$];

  logic [1:0] mem     [32] = '{default: 2'b00};
  logic [1:0] exp_mem [32] = '{default: 2'b00};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  ram82s21_wr u_dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_mask(req_mask), .rd_addr(rd_addr),
    .A(A), .I(I), .CE(CE), .WE0_N(WE0_N), .WE1_N(WE1_N), .WCLK_N(WCLK_N),
    .LATCH_N(LATCH_N), .ram_d(ram_d), .busy(busy), .done(done), .verify_err(verify_err)
  );

  ram82s21_wr #(.SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(0)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_addr(req_addr), .req_data(req_data), .req_mask(req_mask), .rd_addr(rd_addr),
    .A(A2), .I(I2), .CE(CE2), .WE0_N(WE0_N2), .WE1_N(WE1_N2), .WCLK_N(WCLK_N2),
    .LATCH_N(LATCH_N2), .ram_d(2'b11), .busy(busy2), .done(done2), .verify_err(verify_err2)
  );

  // 82S21 model: bits written while CE low and WCLK_N low with their WE low.
  always @(posedge clk) begin
    if (!CE && !WCLK_N) begin
      if (!WE0_N) mem[A][0] <= I[0];
      if (!WE1_N) mem[A][1] <= I[1];
    end
  end
  assign ram_d = CE ? (mem[A] & {1'b1, ~stuck_d0}) : 2'b00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [4:0] a, input logic [1:0] d, input logic [1:0] m,
                      input logic verr, input int acc);
    exp_t e;
    e.addr = a;
    e.word = (exp_mem[a] & ~m) | (d & m);
    e.verr = verr;
    e.acc  = acc;
    exp_mem[a] = e.word;
    sb.push_back(e);
    push_cnt++;
  endtask

  // Write from idle with per-cycle pin checks; returns one cycle after done.
  task automatic do_write(input logic [4:0] a, input logic [1:0] d, input logic [1:0] m,
                          input logic verr);
    logic pulse;
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    req_mask  = m;
    push(a, d, m, verr, cyc + 1);
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = ~a;
    req_data  = ~d;
    req_mask  = ~m;
    for (int k = 1; k <= LAT; k++) begin
      pulse = (k == 2) || (k == 3);
      chk($sformatf("a k=%0d", k), 32'(A), 32'(a));
      chk($sformatf("i k=%0d", k), 32'(I), 32'(d));
      chk($sformatf("ce k=%0d", k), 32'(CE), (k <= 4) ? 32'd0 : 32'd1);
      chk($sformatf("we0_n k=%0d", k), 32'(WE0_N), (pulse && m[0]) ? 32'd0 : 32'd1);
      chk($sformatf("we1_n k=%0d", k), 32'(WE1_N), (pulse && m[1]) ? 32'd0 : 32'd1);
      chk($sformatf("wclk_n k=%0d", k), 32'(WCLK_N), pulse ? 32'd0 : 32'd1);
      chk($sformatf("busy k=%0d", k), 32'(busy), 32'd1);
      chk($sformatf("done_early k=%0d", k), 32'(done), 32'd0);
      @(negedge clk);
    end
    chk("done_cycle_done", 32'(done), 32'd1);
    chk("done_cycle_ce", 32'(CE), 32'd1);
    chk("done_cycle_a", 32'(A), 32'(rd_addr));
    @(negedge clk);
    chk("done_one_pulse", 32'(done), 32'd0);
  endtask

  // Scoreboard: pop an expected write on every done pulse of the main instance.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n === 1'b1) begin
      if (done === 1'b1) begin
        done_cnt++;
        if (sb.size() == 0) begin
          chk("done_unexpected", 32'(done), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("sb_latency", 32'(cyc - e.acc), 32'(LAT));
          chk("sb_mem_word", 32'(mem[e.addr]), 32'(e.word));
          chk("sb_verify_err", 32'(verify_err), 32'(e.verr));
          chk("sb_busy", 32'(busy), 32'd0);
          chk("sb_ready", 32'(req_ready), 32'd1);
        end
      end else if (verify_err !== 1'b0) begin
        chk("verify_err_stray", 32'(verify_err), 32'd0);
      end
    end
  end

  initial begin
    int acc1;
    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_valid2 = 1'b0;
    req_addr   = '0;
    req_data   = '0;
    req_mask   = '0;
    rd_addr    = 5'h0A;
    stuck_d0   = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_ce", 32'(CE), 32'd1);
    chk("rst_we0_n", 32'(WE0_N), 32'd1);
    chk("rst_we1_n", 32'(WE1_N), 32'd1);
    chk("rst_wclk_n", 32'(WCLK_N), 32'd1);
    chk("rst_latch_n", 32'(LATCH_N), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_verify_err", 32'(verify_err), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_i", 32'(I), 32'd0);
    chk("rst_a", 32'(A), 32'h0A);
    rd_addr = 5'h11;
    #1;
    chk("idle_a_follows_rd_addr", 32'(A), 32'h11);
    reset_n = 1'b1;
    @(negedge clk);

    // Full-mask write to top word
    do_write(5'h1F, 2'b10, 2'b11, 1'b0);
    // Clear word 0, then partial write of bit 0 only
    do_write(5'h00, 2'b00, 2'b11, 1'b0);
    do_write(5'h00, 2'b11, 2'b01, 1'b0);
    // Empty mask: sequence runs, no data changes
    do_write(5'h1F, 2'b01, 2'b00, 1'b0);

    // Back-to-back with valid held: second accepted in first's done cycle
    acc1      = cyc + 1;
    req_valid = 1'b1;
    req_addr  = 5'h02;
    req_data  = 2'b01;
    req_mask  = 2'b01;
    push(5'h02, 2'b01, 2'b01, 1'b0, acc1);
    push(5'h01, 2'b11, 2'b10, 1'b0, acc1 + LAT + 1);
    for (int k = 1; k <= 2 * LAT + 3; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_addr = 5'h01;
        req_data = 2'b11;
        req_mask = 2'b10;
      end
      if (k == LAT + 2) req_valid = 1'b0;
      chk($sformatf("b2b_ce k=%0d", k), 32'(CE),
          (((k >= 1) && (k <= 4)) || ((k >= LAT + 2) && (k <= LAT + 5))) ? 32'd0 : 32'd1);
    end

    // Reset asserted mid-pulse: strobes released, request dropped
    req_valid = 1'b1;
    req_addr  = 5'h07;
    req_data  = 2'b11;
    req_mask  = 2'b11;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("mid_wclk_low", 32'(WCLK_N), 32'd0);
    reset_n = 1'b0;
    @(negedge clk);
    chk("midrst_we0_n", 32'(WE0_N), 32'd1);
    chk("midrst_we1_n", 32'(WE1_N), 32'd1);
    chk("midrst_wclk_n", 32'(WCLK_N), 32'd1);
    chk("midrst_ce", 32'(CE), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready", 32'(req_ready), 32'd1);
    chk("midrst_busy_after", 32'(busy), 32'd0);
    repeat (LAT + 2) @(negedge clk);

    // Short windows: PULSE_CYC=1, HOLD_CYC=0
    req_valid2 = 1'b1;
    req_addr   = 5'h15;
    req_data   = 2'b11;
    req_mask   = 2'b11;
    @(negedge clk);
    req_valid2 = 1'b0;
    req_addr   = 5'h00;
    chk("s_ce_setup", 32'(CE2), 32'd0);
    chk("s_a_setup", 32'(A2), 32'h15);
    chk("s_wclk_setup", 32'(WCLK_N2), 32'd1);
    chk("s_we0_setup", 32'(WE0_N2), 32'd1);
    @(negedge clk);
    chk("s_wclk_pulse", 32'(WCLK_N2), 32'd0);
    chk("s_we0_pulse", 32'(WE0_N2), 32'd0);
    chk("s_we1_pulse", 32'(WE1_N2), 32'd0);
    chk("s_a_pulse", 32'(A2), 32'h15);
    chk("s_done_pulse", 32'(done2), 32'd0);
    for (int k = 3; k <= LAT2; k++) begin
      @(negedge clk);
      chk($sformatf("s_done_early k=%0d", k), 32'(done2), 32'd0);
      chk($sformatf("s_wclk k=%0d", k), 32'(WCLK_N2), 32'd1);
    end
    @(negedge clk);
    chk("s_done", 32'(done2), 32'd1);
    chk("s_wclk_done", 32'(WCLK_N2), 32'd1);
    chk("s_we0_done", 32'(WE0_N2), 32'd1);
    chk("s_ce_done", 32'(CE2), 32'd1);
    chk("s_verify_err", 32'(verify_err2), 32'd0);
    chk("s_ready", 32'(req_ready2), 32'd1);
    @(negedge clk);
    chk("s_done_one_pulse", 32'(done2), 32'd0);

`ifdef RAM82S21_VERIFY_EN
    // Readback with D0 stuck at 0 must flag a mismatch with done
    stuck_d0 = 1'b1;
    do_write(5'h03, 2'b01, 2'b11, 1'b1);
    stuck_d0 = 1'b0;
`endif

    repeat (4) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("done_count", 32'(done_cnt), 32'(push_cnt));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its end");
    $fatal(1, "timeout");
  end

endmodule
